// File: rtl/mau_mult_scheduler.sv
// Round-robin scheduler sharing one FP16 multiplier among N_REQ requesters.
// One transaction in flight: accept, issue to the multiplier, wait, return a tagged result.
module mau_mult_scheduler #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = $clog2(N_REQ),
  parameter int MUL_LAT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [N_REQ-1:0]      i_req_valid,
  input  logic [16*N_REQ-1:0]   i_req_x,
  input  logic [16*N_REQ-1:0]   i_req_y,
  output logic [N_REQ-1:0]      o_req_ready,
  output logic [15:0]           o_mul_x,
  output logic [15:0]           o_mul_y,
  output logic                  o_mul_set,
  input  logic [19:0]           i_mul_sum,
  input  logic [4:0]            i_mul_exp,
  input  logic                  i_mul_sign,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [ID_W-1:0]       o_rsp_id,
  output logic [19:0]           o_rsp_sum,
  output logic [4:0]            o_rsp_exp,
  output logic                  o_rsp_sign,
  output logic                  o_busy
);

  localparam int CNT_W = 3;

  // state  | meaning
  // IDLE   | arbitrate among req_valid, accept one operand pair
  // ISSUE  | one-cycle mul_set with latched operands, load latency counter
  // WAIT   | count down multiplier latency, capture result at zero
  // RESP   | hold response until rsp_ready, then advance pointer
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_gid;
  logic [15:0]        r_x;
  logic [15:0]        r_y;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [19:0]        r_rsp_sum;
  logic [4:0]         r_rsp_exp;
  logic               r_rsp_sign;

  logic [2*N_REQ-1:0] w_rot;
  logic               w_any;
  logic [ID_W:0]      w_off;
  logic [ID_W:0]      w_sum;
  logic [ID_W-1:0]    w_gnt;
  logic [15:0]        w_sel_x;
  logic [15:0]        w_sel_y;
  logic               w_accept;
  logic               w_rsp_fire;
  logic [ID_W-1:0]    w_ptr_nxt;

  // Rotate the doubled valid vector so bit 0 is the pointer position; the
  // lowest set bit is then the first requester at or after the pointer.
  always_comb begin
    w_rot = {i_req_valid, i_req_valid} >> r_ptr;
    w_any = 1'b0;
    w_off = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_any = 1'b1;
        w_off = (ID_W+1)'(k);
      end
    end
    w_sum = {1'b0, r_ptr} + w_off;
    if (w_sum >= (ID_W+1)'(N_REQ)) begin
      w_sum = w_sum - (ID_W+1)'(N_REQ);
    end
    w_gnt = w_sum[ID_W-1:0];
  end

  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (ID_W'(k) == w_gnt) begin
        w_sel_x = i_req_x[16*k +: 16];
        w_sel_y = i_req_y[16*k +: 16];
      end
    end
  end

  assign w_accept   = (r_state == S_IDLE) && w_any && !i_reset;
  assign w_rsp_fire = (r_state == S_RESP) && r_rsp_valid && i_rsp_ready;
  assign w_ptr_nxt  = (r_gid == ID_W'(N_REQ-1)) ? '0 : r_gid + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = '0;
    o_mul_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          o_req_ready = N_REQ'(1) << w_gnt;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_mul_set   = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (w_rsp_fire) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr       <= '0;
      r_gid       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_exp   <= '0;
      r_rsp_sign  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x   <= w_sel_x;
            r_y   <= w_sel_y;
            r_gid <= w_gnt;
          end
        end
        S_ISSUE: r_cnt <= CNT_W'(MUL_LAT-1);
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_gid;
            r_rsp_sum   <= i_mul_sum;
            r_rsp_exp   <= i_mul_exp;
            r_rsp_sign  <= i_mul_sign;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= w_ptr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand registers feed the multiplier directly so they hold between issues.
  assign o_mul_x     = r_x;
  assign o_mul_y     = r_y;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_sum   = r_rsp_sum;
  assign o_rsp_exp   = r_rsp_exp;
  assign o_rsp_sign  = r_rsp_sign;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mau_mult_scheduler.sv
// Directed bench for mau_mult_scheduler: a MUL_LAT=1 instance and a MUL_LAT=3 instance,
// each driven by a stub multiplier loaded on mul_set.
`timescale 1ns/1ps
module tb_mau_mult_scheduler;
  localparam int N = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [N-1:0]  req_valid, req_ready;
  logic [16*N-1:0] req_x, req_y;
  logic [15:0]   mul_x, mul_y;
  logic          mul_set, rsp_valid, rsp_ready, rsp_sign, busy;
  logic [19:0]   mul_sum, rsp_sum;
  logic [4:0]    mul_exp, rsp_exp;
  logic          mul_sign;
  logic [IW-1:0] rsp_id;

  logic [N-1:0]  b_req_valid, b_req_ready;
  logic [16*N-1:0] b_req_x, b_req_y;
  logic [15:0]   b_mul_x, b_mul_y;
  logic          b_mul_set, b_rsp_valid, b_rsp_ready, b_rsp_sign, b_busy;
  logic [19:0]   b_mul_sum, b_rsp_sum;
  logic [4:0]    b_mul_exp, b_rsp_exp;
  logic          b_mul_sign;
  logic [IW-1:0] b_rsp_id;

  int n_vec = 0;
  int n_err = 0;

  mau_mult_scheduler #(.N_REQ(N), .MUL_LAT(1)) dut (
    .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .i_req_x(req_x), .i_req_y(req_y),
    .o_req_ready(req_ready), .o_mul_x(mul_x), .o_mul_y(mul_y), .o_mul_set(mul_set),
    .i_mul_sum(mul_sum), .i_mul_exp(mul_exp), .i_mul_sign(mul_sign),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id), .o_rsp_sum(rsp_sum),
    .o_rsp_exp(rsp_exp), .o_rsp_sign(rsp_sign), .o_busy(busy));

  mau_mult_scheduler #(.N_REQ(N), .MUL_LAT(3)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_req_valid(b_req_valid), .i_req_x(b_req_x), .i_req_y(b_req_y),
    .o_req_ready(b_req_ready), .o_mul_x(b_mul_x), .o_mul_y(b_mul_y), .o_mul_set(b_mul_set),
    .i_mul_sum(b_mul_sum), .i_mul_exp(b_mul_exp), .i_mul_sign(b_mul_sign),
    .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready), .o_rsp_id(b_rsp_id), .o_rsp_sum(b_rsp_sum),
    .o_rsp_exp(b_rsp_exp), .o_rsp_sign(b_rsp_sign), .o_busy(b_busy));

  // Stub multipliers
  always @(posedge clk) begin
    if (mul_set) begin
      mul_sum  <= {mul_x[9:0], mul_y[9:0]};
      mul_exp  <= mul_x[14:10];
      mul_sign <= mul_x[15] ^ mul_y[15];
    end
    if (b_mul_set) begin
      b_mul_sum  <= {b_mul_x[9:0], b_mul_y[9:0]};
      b_mul_exp  <= b_mul_x[14:10];
      b_mul_sign <= b_mul_x[15] ^ b_mul_y[15];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    b_req_valid = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 4'hF;
    tick();
    tick();
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_vec++; if ({mul_set, rsp_valid, busy, rsp_sign} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got set/valid/busy/sign=%b want 0000", {mul_set, rsp_valid, busy, rsp_sign}); end
    n_vec++; if ({mul_x, mul_y} !== 32'h0) begin n_err++; $display("FAIL reset_mul_ops: got %h want 00000000", {mul_x, mul_y}); end
    n_vec++; if ({rsp_id, rsp_sum, rsp_exp} !== 27'h0) begin n_err++; $display("FAIL reset_rsp: got id=%0d sum=%h exp=%h want all 0", rsp_id, rsp_sum, rsp_exp); end
    req_valid = '0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req_x[15:0] = 16'h3C00;
    req_y[15:0] = 16'hC000;
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    n_vec++; if ({mul_set, busy, req_ready} !== 6'b110000) begin n_err++; $display("FAIL single_issue: got set/busy/ready=%b want 110000", {mul_set, busy, req_ready}); end
    n_vec++; if ({mul_x, mul_y} !== 32'h3C00C000) begin n_err++; $display("FAIL single_ops: got %h want 3c00c000", {mul_x, mul_y}); end
    tick();
    n_vec++; if ({mul_set, rsp_valid} !== 2'b00) begin n_err++; $display("FAIL single_wait: got set/valid=%b want 00", {mul_set, rsp_valid}); end
    tick();
    n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp_valid: got %b want 1 at T+3", rsp_valid); end
    n_vec++; if ({rsp_id, rsp_sum, rsp_exp, rsp_sign} !== {2'd0, 20'h00000, 5'h0F, 1'b1}) begin n_err++; $display("FAIL single_rsp_data: got id=%0d sum=%h exp=%h sign=%b want 0/00000/0f/1", rsp_id, rsp_sum, rsp_exp, rsp_sign); end
    tick();
    n_vec++; if ({rsp_valid, busy} !== 2'b00) begin n_err++; $display("FAIL single_done: got valid/busy=%b want 00", {rsp_valid, busy}); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_x[16*i +: 16] = 16'(i + 1);
      req_y[16*i +: 16] = 16'h4000;
    end
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int t = 0; t < 5; t++) begin
      int g;
      g = t % N;
      #1;
      n_vec++; if (req_ready !== 4'(1 << g)) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", t, req_ready, 4'(1 << g)); end
      tick();
      n_vec++; if ({req_ready, mul_set} !== 5'b00001) begin n_err++; $display("FAIL rr_busy_block[%0d]: got ready/set=%b want 00001", t, {req_ready, mul_set}); end
      tick();
      tick();
      n_vec++; if ({rsp_valid, rsp_id} !== {1'b1, 2'(g)}) begin n_err++; $display("FAIL rr_rsp_id[%0d]: got valid=%b id=%0d want 1/%0d", t, rsp_valid, rsp_id, g); end
      n_vec++; if (rsp_sum[19:10] !== 10'(g + 1)) begin n_err++; $display("FAIL rr_rsp_sum[%0d]: got %h want %h", t, rsp_sum[19:10], 10'(g + 1)); end
      tick();
    end
  endtask

  task automatic test_stall();
    rsp_ready = 1'b0;
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL stall_grant: got %b want 0010", req_ready); end
    tick();
    tick();
    tick();
    for (int c = 0; c < 10; c++) begin
      n_vec++; if ({rsp_valid, rsp_id, rsp_sum, rsp_exp, rsp_sign} !== {1'b1, 2'd1, 20'h00800, 5'h00, 1'b0}) begin n_err++; $display("FAIL stall_hold[%0d]: got valid=%b id=%0d sum=%h exp=%h sign=%b want 1/1/00800/00/0", c, rsp_valid, rsp_id, rsp_sum, rsp_exp, rsp_sign); end
      n_vec++; if ({req_ready, mul_set} !== 5'b00000) begin n_err++; $display("FAIL stall_block[%0d]: got ready/set=%b want 00000", c, {req_ready, mul_set}); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL stall_release: got %b want 0", rsp_valid); end
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL stall_next_grant: got %b want 0100", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_pointer_wrap();
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL wrap_grant2: got %b want 0100", req_ready); end
    tick(); req_valid = '0; tick(); tick();
    n_vec++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL wrap_id2: got %0d want 2", rsp_id); end
    tick();
    req_valid = 4'b0010;
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL wrap_grant1: got %b want 0010", req_ready); end
    tick(); req_valid = '0; tick(); tick();
    n_vec++; if (rsp_id !== 2'd1) begin n_err++; $display("FAIL wrap_id1: got %0d want 1", rsp_id); end
    tick();
    req_valid = 4'b0110;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL wrap_ptr2: got %b want 0100", req_ready); end
    req_valid = '0;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wrap_drop: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rw_pre_grant: got %b want 0010", req_ready); end
    tick(); req_valid = '0; tick(); tick(); tick();
    req_valid = 4'hF;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rw_grant2: got %b want 0100", req_ready); end
    tick();
    tick();
    n_vec++; if ({busy, mul_set, rsp_valid} !== 3'b100) begin n_err++; $display("FAIL rw_in_wait: got busy/set/valid=%b want 100", {busy, mul_set, rsp_valid}); end
    reset = 1'b1;
    tick();
    n_vec++; if ({req_ready, mul_set, rsp_valid, busy, rsp_sign} !== 8'h00) begin n_err++; $display("FAIL rw_abort_flags: got %b want 00000000", {req_ready, mul_set, rsp_valid, busy, rsp_sign}); end
    n_vec++; if ({mul_x, mul_y, rsp_sum, rsp_exp, rsp_id} !== 59'h0) begin n_err++; $display("FAIL rw_abort_data: got x=%h y=%h sum=%h exp=%h id=%0d want 0", mul_x, mul_y, rsp_sum, rsp_exp, rsp_id); end
    reset = 1'b0;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rw_regrant: got %b want 0001", req_ready); end
    tick();
    tick();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rw_no_stale_rsp: got %b want 0", rsp_valid); end
    tick();
    n_vec++; if ({rsp_valid, rsp_id, rsp_sum[19:10]} !== {1'b1, 2'd0, 10'd1}) begin n_err++; $display("FAIL rw_rsp: got valid=%b id=%0d sum_hi=%h want 1/0/001", rsp_valid, rsp_id, rsp_sum[19:10]); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_mul_lat3();
    b_rsp_ready = 1'b1;
    b_req_x[15:0] = 16'h1234;
    b_req_y[15:0] = 16'h8001;
    b_req_valid = 4'b0001;
    #1;
    n_vec++; if (b_req_ready !== 4'b0001) begin n_err++; $display("FAIL lat3_grant: got %b want 0001", b_req_ready); end
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) b_req_valid = '0;
      n_vec++; if (b_mul_set !== (k == 1)) begin n_err++; $display("FAIL lat3_mul_set[T+%0d]: got %b want %b", k, b_mul_set, (k == 1)); end
      n_vec++; if (b_mul_x !== 16'h1234) begin n_err++; $display("FAIL lat3_mul_x[T+%0d]: got %h want 1234", k, b_mul_x); end
      n_vec++; if (b_rsp_valid !== (k == 5)) begin n_err++; $display("FAIL lat3_rsp_valid[T+%0d]: got %b want %b", k, b_rsp_valid, (k == 5)); end
      if (k == 5) begin
        n_vec++; if ({b_rsp_id, b_rsp_sum, b_rsp_exp, b_rsp_sign} !== {2'd0, 20'h8D001, 5'h04, 1'b1}) begin n_err++; $display("FAIL lat3_rsp_data: got id=%0d sum=%h exp=%h sign=%b want 0/8d001/04/1", b_rsp_id, b_rsp_sum, b_rsp_exp, b_rsp_sign); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = '0; req_x = '0; req_y = '0; rsp_ready = 1'b0;
    b_req_valid = '0; b_req_x = '0; b_req_y = '0; b_rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_pointer_wrap();
    test_reset_in_wait();
    test_mul_lat3();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
